// File: rtl/ram_fifo_pkg.sv
// Shared sizing helpers and parameter checks for the RAM-backed FIFO.
package ram_fifo_pkg;

  localparam int DEF_AE_TH     = 4;
  localparam int DEF_AF_MARGIN = 4;
  localparam int MAX_DATA_W    = 36;

  function automatic int level_w(input int aw);
    return aw + 1;
  endfunction

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic int def_af_th(input int aw);
    return depth_of(aw) - DEF_AF_MARGIN;
  endfunction

  function automatic bit params_ok(
    input int aw,
    input int dw,
    input int ae,
    input int af
  );
    return (aw > 0) && (dw >= 1) && (dw <= MAX_DATA_W)
      && (ae < af) && (af <= depth_of(aw));
  endfunction

endpackage

// File: rtl/ram_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
module ram_fifo_mem #(
  parameter int aw = 11,
  parameter int dw = 8
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [dw-1:0] wdata,
  input  logic          re,
  input  logic [aw-1:0] raddr,
  output logic [dw-1:0] rdata
);

  localparam int DEPTH = 1 << aw;

  logic [dw-1:0] mem [DEPTH];

  // No reset on array or read register so the RAM maps to a block.
  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_fifo_sync.sv
// Single-clock FIFO on an inferred block RAM with level, flags,
// sticky errors, flush and optional output register.
module ram_fifo_sync
  import ram_fifo_pkg::*;
#(
  parameter int addr_int        = 11,
  parameter int data_width_int  = 8,
  parameter int reg_rd_int      = 0,
  parameter int almost_full_th  = def_af_th(addr_int),
  parameter int almost_empty_th = DEF_AE_TH
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      Flush,
  input  logic                      Push,
  input  logic [data_width_int-1:0] WD,
  input  logic                      Pop,
  output logic [data_width_int-1:0] RD,
  output logic                      RDValid,
  output logic                      Full,
  output logic                      Empty,
  output logic                      AlmostFull,
  output logic                      AlmostEmpty,
  output logic [addr_int:0]         Level,
  output logic                      Overflow,
  output logic                      Underflow
);

  localparam int LW = level_w(addr_int);

  localparam logic [LW-1:0] LVL_FULL = LW'(depth_of(addr_int));
  localparam logic [LW-1:0] AF_TH    = LW'(almost_full_th);
  localparam logic [LW-1:0] AE_TH    = LW'(almost_empty_th);

  if (!params_ok(addr_int, data_width_int,
                 almost_empty_th, almost_full_th)) begin : g_bad
    $error("ram_fifo_sync: illegal parameter combination");
  end

  logic [addr_int-1:0]       wptr;
  logic [addr_int-1:0]       rptr;
  logic [LW-1:0]             level_nxt;
  logic                      push_acc;
  logic                      pop_acc;
  logic                      rd_v0;
  logic                      rd_ok;
  logic [data_width_int-1:0] mem_rd;
  logic [data_width_int-1:0] rd0;

  assign push_acc = Push & ~Full & ~Flush;
  assign pop_acc  = Pop & ~Empty & ~Flush;

  always_comb begin
    level_nxt = Level;
    unique case (1'b1)
      Flush:                  level_nxt = '0;
      push_acc & ~pop_acc:    level_nxt = Level + 1'b1;
      pop_acc & ~push_acc:    level_nxt = Level - 1'b1;
      default:                level_nxt = Level;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      Level       <= '0;
      Full        <= 1'b0;
      Empty       <= 1'b1;
      AlmostFull  <= 1'b0;
      AlmostEmpty <= 1'b1;
      Overflow    <= 1'b0;
      Underflow   <= 1'b0;
      rd_v0       <= 1'b0;
      rd_ok       <= 1'b0;
    end else begin
      Level       <= level_nxt;
      Full        <= level_nxt == LVL_FULL;
      Empty       <= level_nxt == '0;
      AlmostFull  <= level_nxt >= AF_TH;
      AlmostEmpty <= level_nxt <= AE_TH;
      rd_v0       <= pop_acc;
      if (pop_acc) rd_ok <= 1'b1;
      if (Flush) begin
        wptr      <= '0;
        rptr      <= '0;
        Overflow  <= 1'b0;
        Underflow <= 1'b0;
      end else begin
        if (push_acc) wptr <= wptr + 1'b1;
        if (pop_acc) rptr <= rptr + 1'b1;
        if (Push & Full) Overflow <= 1'b1;
        if (Pop & Empty) Underflow <= 1'b1;
      end
    end
  end

  ram_fifo_mem #(
    .aw (addr_int),
    .dw (data_width_int)
  ) u_mem (
    .Clk   (Clk),
    .we    (push_acc),
    .waddr (wptr),
    .wdata (WD),
    .re    (pop_acc),
    .raddr (rptr),
    .rdata (mem_rd)
  );

  // RAM read register has no reset; mask it until the first real read.
  assign rd0 = rd_ok ? mem_rd : '0;

  if (reg_rd_int == 1) begin : g_rd_reg
    logic [data_width_int-1:0] rd_q;
    logic                      rdv_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        rd_q  <= '0;
        rdv_q <= 1'b0;
      end else begin
        rdv_q <= rd_v0 & ~Flush;
        if (rd_v0) rd_q <= rd0;
      end
    end

    assign RD      = rd_q;
    assign RDValid = rdv_q;
  end else begin : g_rd_direct
    assign RD      = rd0;
    assign RDValid = rd_v0;
  end

endmodule

// File: tb/tb_ram_fifo_sync.sv
// Directed bench for ram_fifo_sync: one instance per read latency,
// both driven by the same stimulus.
module tb_ram_fifo_sync;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Flush = 1'b0;
  logic       Push = 1'b0;
  logic       Pop = 1'b0;
  logic [7:0] WD = 8'h00;

  logic [7:0] rd0, rd1;
  logic       v0, v1;
  logic       full0, full1, empty0, empty1;
  logic       af0, af1, ae0, ae1;
  logic [4:0] lvl0, lvl1;
  logic       ovf0, ovf1, unf0, unf1;

  int total = 0;
  int bad = 0;

  logic       pv;
  logic [7:0] pd;

  always #5 Clk = ~Clk;

  ram_fifo_sync #(
    .addr_int(4), .data_width_int(8), .reg_rd_int(0),
    .almost_full_th(12), .almost_empty_th(4)
  ) u0 (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .Push(Push), .WD(WD),
    .Pop(Pop), .RD(rd0), .RDValid(v0), .Full(full0), .Empty(empty0),
    .AlmostFull(af0), .AlmostEmpty(ae0), .Level(lvl0),
    .Overflow(ovf0), .Underflow(unf0)
  );

  ram_fifo_sync #(
    .addr_int(4), .data_width_int(8), .reg_rd_int(1),
    .almost_full_th(12), .almost_empty_th(4)
  ) u1 (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .Push(Push), .WD(WD),
    .Pop(Pop), .RD(rd1), .RDValid(v1), .Full(full1), .Empty(empty1),
    .AlmostFull(af1), .AlmostEmpty(ae1), .Level(lvl1),
    .Overflow(ovf1), .Underflow(unf1)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    repeat (2) tick();
    total++;
    if ({full0, af0, empty0, ae0} !== 4'b0011) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0011", {full0, af0, empty0, ae0});
    end
    total++;
    if (lvl0 !== 5'd0 || v0 !== 1'b0 || rd0 !== 8'h00) begin
      bad++;
      $display("FAIL reset_out got=%0d/%b/%h exp=0/0/00", lvl0, v0, rd0);
    end
    total++;
    if (ovf0 !== 1'b0 || unf0 !== 1'b0 || v1 !== 1'b0 || rd1 !== 8'h00) begin
      bad++;
      $display("FAIL reset_misc got=%b%b%b/%h exp=000/00", ovf0, unf0, v1, rd1);
    end
    Rst_n = 1'b1;
    tick();
    total++;
    if (empty0 !== 1'b1 || ae0 !== 1'b1 || lvl0 !== 5'd0 || v0 !== 1'b0) begin
      bad++;
      $display("FAIL idle got=%b%b/%0d/%b exp=11/0/0", empty0, ae0, lvl0, v0);
    end
  endtask

  task automatic test_fill;
    logic [4:0] lv;
    for (int i = 0; i < 16; i++) begin
      Push = 1'b1;
      WD = 8'h10 + 8'(i);
      tick();
      lv = 5'(i + 1);
      total++;
      if (lvl0 !== lv) begin
        bad++;
        $display("FAIL fill_level got=%0d exp=%0d", lvl0, lv);
      end
      total++;
      if ({full0, af0, empty0, ae0} !== {lv == 5'd16, lv >= 5'd12, 1'b0, lv <= 5'd4}) begin
        bad++;
        $display("FAIL fill_flags lvl=%0d got=%b", lv, {full0, af0, empty0, ae0});
      end
    end
    WD = 8'hAA;
    tick();
    Push = 1'b0;
    total++;
    if (lvl0 !== 5'd16 || full0 !== 1'b1 || ovf0 !== 1'b1 || unf0 !== 1'b0) begin
      bad++;
      $display("FAIL overflow got=%0d/%b/%b/%b exp=16/1/1/0", lvl0, full0, ovf0, unf0);
    end
  endtask

  task automatic test_drain;
    logic [4:0] lv;
    logic [7:0] ed;
    pv = 1'b0;
    pd = 8'h00;
    for (int i = 0; i < 16; i++) begin
      Pop = 1'b1;
      tick();
      lv = 5'(15 - i);
      ed = 8'h10 + 8'(i);
      total++;
      if (v0 !== 1'b1 || rd0 !== ed) begin
        bad++;
        $display("FAIL drain_rd got=%b/%h exp=1/%h", v0, rd0, ed);
      end
      total++;
      if (lvl0 !== lv || empty0 !== (lv == 5'd0) || ae0 !== (lv <= 5'd4)) begin
        bad++;
        $display("FAIL drain_level got=%0d/%b%b exp=%0d", lvl0, empty0, ae0, lv);
      end
      total++;
      if (v1 !== pv || (pv && rd1 !== pd)) begin
        bad++;
        $display("FAIL drain_lag got=%b/%h exp=%b/%h", v1, rd1, pv, pd);
      end
      pv = 1'b1;
      pd = ed;
    end
    tick();
    Pop = 1'b0;
    total++;
    if (unf0 !== 1'b1 || v0 !== 1'b0 || lvl0 !== 5'd0) begin
      bad++;
      $display("FAIL underflow got=%b/%b/%0d exp=1/0/0", unf0, v0, lvl0);
    end
    total++;
    if (v1 !== 1'b1 || rd1 !== 8'h1F) begin
      bad++;
      $display("FAIL drain_lag_last got=%b/%h exp=1/1f", v1, rd1);
    end
    tick();
    total++;
    if (v0 !== 1'b0 || v1 !== 1'b0 || rd0 !== 8'h1F) begin
      bad++;
      $display("FAIL drain_idle got=%b%b/%h exp=00/1f", v0, v1, rd0);
    end
  endtask

  task automatic test_stream;
    logic [7:0] ed;
    for (int i = 0; i < 8; i++) begin
      Push = 1'b1;
      WD = 8'h40 + 8'(i);
      tick();
    end
    pv = 1'b0;
    pd = 8'h00;
    for (int k = 0; k < 40; k++) begin
      Push = 1'b1;
      Pop = 1'b1;
      WD = 8'h48 + 8'(k);
      tick();
      ed = 8'h40 + 8'(k);
      total++;
      if (lvl0 !== 5'd8 || v0 !== 1'b1 || rd0 !== ed) begin
        bad++;
        $display("FAIL stream k=%0d got=%0d/%b/%h exp=8/1/%h", k, lvl0, v0, rd0, ed);
      end
      total++;
      if (v1 !== pv || (pv && rd1 !== pd)) begin
        bad++;
        $display("FAIL stream_lag k=%0d got=%b/%h exp=%b/%h", k, v1, rd1, pv, pd);
      end
      pv = 1'b1;
      pd = ed;
    end
    Push = 1'b0;
    Pop = 1'b0;
  endtask

  task automatic test_flush;
    Push = 1'b1;
    WD = 8'hEE;
    tick();
    total++;
    if (lvl0 !== 5'd9 || ovf0 !== 1'b1) begin
      bad++;
      $display("FAIL preflush got=%0d/%b exp=9/1", lvl0, ovf0);
    end
    Pop = 1'b1;
    WD = 8'hEF;
    tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    Push = 1'b0;
    Pop = 1'b0;
    total++;
    if (lvl0 !== 5'd0 || {full0, af0, empty0, ae0} !== 4'b0011) begin
      bad++;
      $display("FAIL flush_state got=%0d/%b exp=0/0011", lvl0, {full0, af0, empty0, ae0});
    end
    total++;
    if (ovf0 !== 1'b0 || unf0 !== 1'b0 || v0 !== 1'b0 || v1 !== 1'b0 || lvl1 !== 5'd0) begin
      bad++;
      $display("FAIL flush_clr got=%b%b%b%b/%0d exp=0000/0", ovf0, unf0, v0, v1, lvl1);
    end
    Push = 1'b1;
    WD = 8'h5A;
    tick();
    Push = 1'b0;
    total++;
    if (u0.u_mem.mem[0] !== 8'h5A) begin
      bad++;
      $display("FAIL flush_addr0 got=%h exp=5a", u0.u_mem.mem[0]);
    end
    Pop = 1'b1;
    tick();
    Pop = 1'b0;
    total++;
    if (v0 !== 1'b1 || rd0 !== 8'h5A) begin
      bad++;
      $display("FAIL flush_read got=%b/%h exp=1/5a", v0, rd0);
    end
    tick();
    total++;
    if (v1 !== 1'b1 || rd1 !== 8'h5A) begin
      bad++;
      $display("FAIL flush_read_lag got=%b/%h exp=1/5a", v1, rd1);
    end
  endtask

  task automatic test_empty_pushpop;
    Push = 1'b1;
    Pop = 1'b1;
    WD = 8'h3C;
    tick();
    Push = 1'b0;
    Pop = 1'b0;
    total++;
    if (lvl0 !== 5'd1 || unf0 !== 1'b1 || v0 !== 1'b0) begin
      bad++;
      $display("FAIL empty_pp got=%0d/%b/%b exp=1/1/0", lvl0, unf0, v0);
    end
    Pop = 1'b1;
    tick();
    Pop = 1'b0;
    total++;
    if (v0 !== 1'b1 || rd0 !== 8'h3C || lvl0 !== 5'd0) begin
      bad++;
      $display("FAIL empty_pp_read got=%b/%h/%0d exp=1/3c/0", v0, rd0, lvl0);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) begin
      Push = 1'b1;
      WD = 8'h60 + 8'(i);
      tick();
    end
    #2;
    Rst_n = 1'b0;
    #1;
    total++;
    if (lvl0 !== 5'd0 || empty0 !== 1'b1 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got=%0d/%b/%b%b exp=0/1/00", lvl0, empty0, ovf0, unf0);
    end
    Push = 1'b0;
    tick();
    Rst_n = 1'b1;
    tick();
    Push = 1'b1;
    WD = 8'h77;
    tick();
    Push = 1'b0;
    total++;
    if (u0.u_mem.mem[0] !== 8'h77 || lvl0 !== 5'd1) begin
      bad++;
      $display("FAIL reset_addr0 got=%h/%0d exp=77/1", u0.u_mem.mem[0], lvl0);
    end
    Pop = 1'b1;
    tick();
    Pop = 1'b0;
    total++;
    if (v0 !== 1'b1 || rd0 !== 8'h77) begin
      bad++;
      $display("FAIL reset_read got=%b/%h exp=1/77", v0, rd0);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_empty_pushpop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
